firebird_alu_seq: RTL and testbench

//  Multi-cycle execute-stage ALU downstream of the ALU control decoder.
//  - Consumes the 4-bit alu_ctrl_signal plus two operands, accepted on a valid/ready handshake.
//  - Logic, add and compare ops complete in one cycle; shifts use a 1-bit-per-cycle serial shifter.
//  - Result and branch zero flag are presented on a valid/ready handshake to the writeback/branch logic.

---
 rtl/firebird_alu_pkg.sv | 21 ++
 rtl/firebird_alu_core.sv | 28 ++
 rtl/firebird_alu_seq.sv | 98 +++++++++
 tb/tb_firebird_alu_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/firebird_alu_pkg.sv
// firebird_alu_pkg: op codes, FSM state encoding and shift-op helper for the sequential ALU
package firebird_alu_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
  function automatic logic is_shift(input logic [3:0] code);
    return code == OP_SLL || code == OP_SRL || code == OP_SRA;
  endfunction
endpackage

// File: rtl/firebird_alu_core.sv
// firebird_alu_core: combinational single-cycle ALU ops; shift codes are legal here but produced by the top
module firebird_alu_core
  import firebird_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (ctrl)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_XOR:  result = a ^ b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      OP_SLL, OP_SRL, OP_SRA: result = '0;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/firebird_alu_seq.sv
// firebird_alu_seq: multi-cycle execute ALU with serial 1-bit/cycle shifter and valid/ready handshakes
module firebird_alu_seq
  import firebird_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl_signal,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            illegal
);
  state_e              state_q, state_d;
  logic [XLEN-1:0]     shreg_q, shreg_d, res_q, res_d, core_res, sh_nxt;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d, shamt;
  logic [3:0]          op_q, op_d;
  logic                zero_q, zero_d, ill_q, ill_d, core_ill;
  firebird_alu_core #(.XLEN(XLEN)) u_core (
    .ctrl    (alu_ctrl_signal),
    .a       (src_a),
    .b       (src_b),
    .result  (core_res),
    .illegal (core_ill)
  );
  assign shamt  = src_b[SHAMT_W-1:0];
  assign sh_nxt = op_q == OP_SLL ? shreg_q << 1 :
                  op_q == OP_SRA ? {shreg_q[XLEN-1], shreg_q[XLEN-1:1]} : shreg_q >> 1;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (is_shift(alu_ctrl_signal)) begin
          shreg_d = src_a;
          cnt_d   = shamt;
          op_d    = alu_ctrl_signal;
          ill_d   = 1'b0;
          res_d   = src_a;
          zero_d  = src_a == '0;
          state_d = shamt == '0 ? DONE : SHIFT;
        end else begin
          res_d   = core_res;
          zero_d  = core_res == '0;
          ill_d   = core_ill;
          state_d = DONE;
        end
      end
      SHIFT: begin
        shreg_d = sh_nxt;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          res_d   = sh_nxt;
          zero_d  = sh_nxt == '0;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      op_q    <= OP_AND;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign alu_result = res_q;
  assign zero       = zero_q;
  assign illegal    = ill_q;
endmodule

// File: tb/tb_firebird_alu_seq.sv
// tb_firebird_alu_seq: directed and randomized checks of the sequential ALU against hand values and a model
module tb_firebird_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, in_ready, out_valid, zero, illegal;
  logic [3:0]  ctrl;
  logic [31:0] src_a, src_b, alu_result;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  firebird_alu_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .alu_ctrl_signal (ctrl),
    .src_a           (src_a),
    .src_b           (src_b),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .alu_result      (alu_result),
    .zero            (zero),
    .illegal         (illegal)
  );
  function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        il;
    r  = 32'd0;
    il = 1'b0;
    case (c)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h3: r = a ^ b;
      4'h6: r = a - b;
      4'h7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h8: r = (a < b) ? 32'd1 : 32'd0;
      4'h4: r = a << b[4:0];
      4'h5: r = a >> b[4:0];
      4'hD: r = $signed(a) >>> b[4:0];
      default: il = 1'b1;
    endcase
    return {il, r};
  endfunction
  // Called at posedge+1 with the DUT idle; returns edges from accept to out_valid.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output int lat);
    ctrl = c; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL op_timeout ctrl=%h: out_valid=%b after %0d cycles, required 1", c, out_valid, lat);
    end
  endtask
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    int  lat;
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ctrl = 4'h0; src_a = 0; src_b = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: valid=%b res=%h zero=%b ill=%b, required 0/0/0/0", out_valid, alu_result, zero, illegal);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(4'h2, 32'd3, 32'd4, lat);
    checks++;
    if (alu_result !== 32'd7) begin
      errors++;
      $display("FAIL reset_pre_add: res=%h, required 00000007", alu_result);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_result !== 32'd0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_done: valid=%b res=%h zero=%b, required 0/0/0", out_valid, alu_result, zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
    ctrl = 4'h4; src_a = 32'd1; src_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_result !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_shift: valid=%b res=%h ready=%b, required 0/0/1", out_valid, alu_result, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: out_valid seen=%b after aborted shift, required 0", seen);
    end
  endtask
  task automatic test_add_sub();
    int lat;
    run_op(4'h2, 32'h7FFF_FFFF, 32'd1, lat);
    checks++;
    if (lat !== 1 || alu_result !== 32'h8000_0000 || zero !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap: lat=%0d res=%h zero=%b ill=%b, required 1/80000000/0/0", lat, alu_result, zero, illegal);
    end
    consume();
    run_op(4'h6, 32'd5, 32'd5, lat);
    checks++;
    if (lat !== 1 || alu_result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_zero: lat=%0d res=%h zero=%b, required 1/00000000/1", lat, alu_result, zero);
    end
    consume();
    run_op(4'h6, 32'd0, 32'd1, lat);
    checks++;
    if (alu_result !== 32'hFFFF_FFFF || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_wrap: res=%h zero=%b, required FFFFFFFF/0", alu_result, zero);
    end
    consume();
  endtask
  task automatic test_shift();
    int lat;
    run_op(4'hD, 32'h8000_0000, 32'd31, lat);
    checks++;
    if (lat !== 32 || alu_result !== 32'hFFFF_FFFF || zero !== 1'b0) begin
      errors++;
      $display("FAIL sra_31: lat=%0d res=%h zero=%b, required 32/FFFFFFFF/0", lat, alu_result, zero);
    end
    consume();
    run_op(4'h4, 32'h1234_5678, 32'd0, lat);
    checks++;
    if (lat !== 1 || alu_result !== 32'h1234_5678) begin
      errors++;
      $display("FAIL sll_0: lat=%0d res=%h, required 1/12345678", lat, alu_result);
    end
    consume();
    run_op(4'h4, 32'h8000_0001, 32'h0000_0021, lat);
    checks++;
    if (lat !== 2 || alu_result !== 32'h0000_0002) begin
      errors++;
      $display("FAIL sll_shamt_low_bits: lat=%0d res=%h, required 2/00000002", lat, alu_result);
    end
    consume();
    run_op(4'h5, 32'h8000_0000, 32'd31, lat);
    checks++;
    if (lat !== 32 || alu_result !== 32'd1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL srl_31: lat=%0d res=%h zero=%b, required 32/00000001/0", lat, alu_result, zero);
    end
    consume();
    run_op(4'h4, 32'h0000_00F0, 32'd28, lat);
    checks++;
    if (lat !== 29 || alu_result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL sll_to_zero: lat=%0d res=%h zero=%b, required 29/00000000/1", lat, alu_result, zero);
    end
    consume();
  endtask
  task automatic test_compare_illegal();
    int lat;
    run_op(4'h7, 32'hFFFF_FFFF, 32'd1, lat);
    checks++;
    if (alu_result !== 32'd1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL slt_signed: res=%h zero=%b, required 00000001/0", alu_result, zero);
    end
    consume();
    run_op(4'h8, 32'hFFFF_FFFF, 32'd1, lat);
    checks++;
    if (alu_result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL sltu: res=%h zero=%b, required 00000000/1", alu_result, zero);
    end
    consume();
    run_op(4'hF, 32'hDEAD_BEEF, 32'h1234_5678, lat);
    checks++;
    if (lat !== 1 || illegal !== 1'b1 || alu_result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL illegal_1111: lat=%0d ill=%b res=%h zero=%b, required 1/1/00000000/1", lat, illegal, alu_result, zero);
    end
    consume();
    run_op(4'h1, 32'hF0F0_0000, 32'h0000_0F0F, lat);
    checks++;
    if (illegal !== 1'b0 || alu_result !== 32'hF0F0_0F0F) begin
      errors++;
      $display("FAIL or_clears_illegal: ill=%b res=%h, required 0/F0F00F0F", illegal, alu_result);
    end
    consume();
  endtask
  task automatic test_backpressure();
    int   lat;
    logic bad;
    run_op(4'h3, 32'hAAAA_0000, 32'h0000_5555, lat);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ctrl = 4'h2; src_a = 32'd1; src_b = 32'd1; in_valid = (i % 2) == 0;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_result !== 32'hAAAA_5555 || zero !== 1'b0) bad = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL hold_stable: valid=%b ready=%b res=%h, required 1/0/AAAA5555", out_valid, in_ready, alu_result);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_idle: valid=%b ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask
  task automatic test_sample_hold();
    int lat;
    ctrl = 4'h5; src_a = 32'hF000_0000; src_b = 32'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    ctrl = 4'h4; src_a = 32'h0000_0001; src_b = 32'd3;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    checks++;
    if (lat !== 9 || alu_result !== 32'h00F0_0000) begin
      errors++;
      $display("FAIL sampled_at_accept: lat=%0d res=%h, required 9/00F00000", lat, alu_result);
    end
    consume();
  endtask
  task automatic test_back_to_back();
    logic [3:0]  codes [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h4, 4'h5, 4'hD, 4'hB};
    logic [3:0]  c;
    logic [31:0] a, b;
    logic [32:0] exp;
    int          lat, exp_lat;
    for (int n = 0; n < 40; n++) begin
      c = codes[$urandom_range(0, 10)];
      a = $urandom;
      b = $urandom;
      if (n % 5 == 0) b = a;
      exp = ref_alu(c, a, b);
      exp_lat = (c == 4'h4 || c == 4'h5 || c == 4'hD) ? 1 + int'(b[4:0]) : 1;
      run_op(c, a, b, lat);
      checks++;
      if (alu_result !== exp[31:0] || illegal !== exp[32] || zero !== (exp[31:0] == 32'd0) || lat !== exp_lat || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d ctrl=%h a=%h b=%h: res=%h ill=%b zero=%b lat=%0d, required %h/%b/%b/%0d",
                 n, c, a, b, alu_result, illegal, zero, lat, exp[31:0], exp[32], exp[31:0] == 32'd0, exp_lat);
      end
      consume();
    end
  endtask
  initial begin
    test_reset();
    test_add_sub();
    test_shift();
    test_compare_illegal();
    test_backpressure();
    test_sample_hold();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
